// File: rtl/m_ser_check.sv
// Receive-side m-sequence checker: syncs the PN bit clock/data into clk, self-synchronises
// a 3-stage reference (b[n] = b[n-1] ^ b[n-3]), locks, then flags and counts bit errors.
module m_ser_check #(
  parameter int LOCK_CNT   = 7,
  parameter int WIN_LEN    = 16,
  parameter int ERR_THRESH = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ser_clk,
  input  logic             ser_in,
  output logic             rx_valid,
  output logic             rx_bit,
  output logic             bit_err,
  output logic             locked,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = $clog2(WIN_LEN + 1);
  localparam int WERR_W  = $clog2(ERR_THRESH + 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCK   = 2'd2
  } state_t;

  state_t             state_r;
  logic               ser_clk_meta_r, ser_clk_sync_r, ser_clk_prev_r;
  logic               ser_in_meta_r, ser_in_sync_r;
  logic [2:0]         hist_r;
  logic [1:0]         fill_r;
  logic [MATCH_W-1:0] match_r;
  logic [WIN_W-1:0]   win_r;
  logic [WERR_W-1:0]  win_err_r;

  logic               strobe_s;
  logic               pred_s;
  logic               mismatch_s;
  logic [2:0]         rx_shift_s;
  logic [WERR_W-1:0]  win_err_inc_s;
  logic               lock_lost_s;
  logic               win_wrap_s;
  logic [CNT_W-1:0]   err_cnt_inc_s;
  logic [CNT_W-1:0]   bit_cnt_inc_s;

  // Two-flop synchronisers plus a history flop on ser_clk for falling-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ser_clk_meta_r <= 1'b0;
      ser_clk_sync_r <= 1'b0;
      ser_clk_prev_r <= 1'b0;
      ser_in_meta_r  <= 1'b0;
      ser_in_sync_r  <= 1'b0;
    end else begin
      ser_clk_meta_r <= ser_clk;
      ser_clk_sync_r <= ser_clk_meta_r;
      ser_clk_prev_r <= ser_clk_sync_r;
      ser_in_meta_r  <= ser_in;
      ser_in_sync_r  <= ser_in_meta_r;
    end
  end

  // Strobe, prediction and saturating-increment helpers for the FSM
  always_comb begin
    strobe_s      = ser_clk_prev_r & ~ser_clk_sync_r;
    pred_s        = hist_r[0] ^ hist_r[2];
    mismatch_s    = ser_in_sync_r ^ pred_s;
    rx_shift_s    = {hist_r[1:0], ser_in_sync_r};
    win_err_inc_s = win_err_r + WERR_W'(1);
    lock_lost_s   = mismatch_s & (win_err_inc_s == WERR_W'(ERR_THRESH));
    win_wrap_s    = (win_r == WIN_W'(WIN_LEN - 1));
    err_cnt_inc_s = (&err_cnt) ? err_cnt : err_cnt + CNT_W'(1);
    bit_cnt_inc_s = (&bit_cnt) ? bit_cnt : bit_cnt + CNT_W'(1);
  end

  // Acquisition / flywheel FSM with registered outputs, advanced once per strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_SEARCH;
      hist_r    <= 3'b000;
      fill_r    <= 2'd0;
      match_r   <= MATCH_W'(0);
      win_r     <= WIN_W'(0);
      win_err_r <= WERR_W'(0);
      rx_valid  <= 1'b0;
      rx_bit    <= 1'b0;
      bit_err   <= 1'b0;
      locked    <= 1'b0;
      err_cnt   <= CNT_W'(0);
      bit_cnt   <= CNT_W'(0);
    end else begin
      rx_valid <= strobe_s;
      bit_err  <= 1'b0;
      if (strobe_s) begin
        rx_bit <= ser_in_sync_r;
        case (state_r)
          ST_SEARCH: begin
            hist_r <= rx_shift_s;
            if (fill_r != 2'd3) begin
              fill_r <= fill_r + 2'd1;
            end
            // Fill reaches 3 on this strobe; an all-zero history can never seed the LFSR
            if ((fill_r >= 2'd2) && (rx_shift_s != 3'b000)) begin
              state_r <= ST_VERIFY;
              match_r <= MATCH_W'(0);
            end
          end
          ST_VERIFY: begin
            hist_r <= rx_shift_s;
            if (rx_shift_s == 3'b000) begin
              state_r <= ST_SEARCH;
              fill_r  <= 2'd0;
              match_r <= MATCH_W'(0);
            end else if (!mismatch_s) begin
              match_r <= match_r + MATCH_W'(1);
              if (match_r == MATCH_W'(LOCK_CNT - 1)) begin
                state_r   <= ST_LOCK;
                locked    <= 1'b1;
                win_r     <= WIN_W'(0);
                win_err_r <= WERR_W'(0);
              end
            end else begin
              match_r <= MATCH_W'(0);
            end
          end
          ST_LOCK: begin
            // Flywheel: the reference advances on its own prediction, not on line data
            hist_r  <= {hist_r[1:0], pred_s};
            bit_cnt <= bit_cnt_inc_s;
            if (mismatch_s) begin
              bit_err <= 1'b1;
              err_cnt <= err_cnt_inc_s;
            end
            if (lock_lost_s) begin
              state_r   <= ST_SEARCH;
              locked    <= 1'b0;
              hist_r    <= 3'b000;
              fill_r    <= 2'd0;
              match_r   <= MATCH_W'(0);
              win_r     <= WIN_W'(0);
              win_err_r <= WERR_W'(0);
            end else if (win_wrap_s) begin
              win_r     <= WIN_W'(0);
              win_err_r <= WERR_W'(0);
            end else begin
              win_r     <= win_r + WIN_W'(1);
              win_err_r <= mismatch_s ? win_err_inc_s : win_err_r;
            end
          end
          default: begin
            state_r <= ST_SEARCH;
            locked  <= 1'b0;
            hist_r  <= 3'b000;
            fill_r  <= 2'd0;
            match_r <= MATCH_W'(0);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_m_ser_check.sv
// Randomised bench for m_ser_check: drives a PN stream with injected errors and compares every
// received bit against a model that tracks lock phase inside the 7-bit m-sequence.
module tb_m_ser_check;
  localparam int LOCK_CNT   = 7;
  localparam int WIN_LEN    = 16;
  localparam int ERR_THRESH = 3;
  localparam int CW         = 6;
  localparam int MAXC       = (1 << CW) - 1;

  logic clk = 1'b0, reset_n = 1'b0, ser_clk = 1'b0, ser_in = 1'b0;
  logic rx_valid, rx_bit, bit_err, locked;
  logic [CW-1:0] err_cnt, bit_cnt;

  int checks = 0, failures = 0;
  int seq[7] = '{0, 0, 1, 1, 1, 0, 1};
  int tx_k = 0, sent = 0, pulses = 0, stray = 0;

  int m_state, m_fill, m_match, m_k, m_win, m_werr, m_errs, m_bits;
  int m_q[3];
  logic m_lock, e_err, x_b;
  logic c_valid, c_bit, c_err, c_locked;
  logic [CW-1:0] c_errc, c_bitc;

  m_ser_check #(.LOCK_CNT(LOCK_CNT), .WIN_LEN(WIN_LEN), .ERR_THRESH(ERR_THRESH), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .ser_clk(ser_clk), .ser_in(ser_in),
    .rx_valid(rx_valid), .rx_bit(rx_bit), .bit_err(bit_err), .locked(locked),
    .err_cnt(err_cnt), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_valid) pulses++;
      if (bit_err && !rx_valid) stray++;
    end
  end

  task automatic model_reset();
    m_state = 0; m_fill = 0; m_match = 0; m_k = 0; m_win = 0; m_werr = 0;
    m_errs = 0; m_bits = 0; m_q = '{0, 0, 0}; m_lock = 1'b0;
  endtask

  // Model: SEARCH/VERIFY from the last three received bits; LOCK tracks a phase index into seq.
  task automatic model_step(input int b, output logic e);
    int p;
    e = 1'b0;
    case (m_state)
      0: begin
        m_q[0] = m_q[1]; m_q[1] = m_q[2]; m_q[2] = b;
        if (m_fill < 3) m_fill++;
        if (m_fill == 3 && (m_q[0] + m_q[1] + m_q[2]) != 0) begin m_state = 1; m_match = 0; end
      end
      1: begin
        p = m_q[2] ^ m_q[0];
        m_q[0] = m_q[1]; m_q[1] = m_q[2]; m_q[2] = b;
        if ((m_q[0] + m_q[1] + m_q[2]) == 0) begin m_state = 0; m_fill = 0; m_match = 0; end
        else if (b == p) begin
          m_match++;
          if (m_match == LOCK_CNT) begin
            m_state = 2; m_win = 0; m_werr = 0;
            for (int j = 0; j < 7; j++)
              if (seq[(j+4)%7] == m_q[0] && seq[(j+5)%7] == m_q[1] && seq[(j+6)%7] == m_q[2]) m_k = j;
          end
        end else m_match = 0;
      end
      default: begin
        e = (b != seq[m_k]);
        m_k = (m_k + 1) % 7;
        if (m_bits < MAXC) m_bits++;
        if (e) begin
          if (m_errs < MAXC) m_errs++;
          m_werr++;
        end
        if (e && m_werr == ERR_THRESH) begin
          m_state = 0; m_fill = 0; m_match = 0; m_q = '{0, 0, 0};
        end else if (m_win == WIN_LEN - 1) begin m_win = 0; m_werr = 0; end
        else m_win++;
      end
    endcase
    m_lock = (m_state == 2);
  endtask

  // Send one bit (data changes on rising ser_clk), capture the DUT's per-bit outputs, step model.
  task automatic xfer_raw(input logic b);
    int hi, lo;
    hi = $urandom_range(2, 8);
    lo = $urandom_range(6, 10);
    @(posedge clk); #3; ser_in = b; ser_clk = 1'b1;
    repeat (hi) @(posedge clk);
    #3; ser_clk = 1'b0;
    c_valid = 1'b0; c_bit = 1'b0; c_err = 1'b0; c_locked = 1'b0; c_errc = '0; c_bitc = '0;
    for (int i = 0; i < lo; i++) begin
      @(negedge clk);
      if (rx_valid && !c_valid) begin
        c_valid = 1'b1; c_bit = rx_bit; c_err = bit_err; c_locked = locked;
        c_errc = err_cnt; c_bitc = bit_cnt;
      end
    end
    sent++;
    x_b = b;
    model_step(int'(b), e_err);
  endtask

  task automatic tx_bit(input logic inv);
    logic b;
    b = logic'(seq[tx_k][0]) ^ inv;
    tx_k = (tx_k + 1) % 7;
    xfer_raw(b);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rx_valid, rx_bit, bit_err, locked, err_cnt, bit_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_state got v=%b b=%b e=%b l=%b ec=%0d bc=%0d exp all 0",
               rx_valid, rx_bit, bit_err, locked, err_cnt, bit_cnt);
    end
    #3; reset_n = 1'b1;
  endtask

  task automatic test_acquire();
    tx_k = 0;
    for (int i = 0; i < 20; i++) begin
      tx_bit(1'b0);
      checks++;
      if ({c_valid, c_bit, c_err, c_locked, c_errc, c_bitc} !==
          {1'b1, x_b, e_err, m_lock, m_errs[CW-1:0], m_bits[CW-1:0]}) begin
        failures++;
        $display("FAIL acquire bit%0d got v=%b b=%b e=%b l=%b ec=%0d bc=%0d exp b=%b e=%b l=%b ec=%0d bc=%0d",
                 i, c_valid, c_bit, c_err, c_locked, c_errc, c_bitc, x_b, e_err, m_lock, m_errs, m_bits);
      end
      if (i == 8 || i == 9) begin
        checks++;
        if (c_locked !== (i == 9)) begin
          failures++;
          $display("FAIL lock_at_10th strobe%0d got locked=%b exp %b", i + 1, c_locked, i == 9);
        end
      end
    end
  endtask

  task automatic test_single_error();
    for (int i = 0; i < 21; i++) begin
      tx_bit(i == 0);
      checks++;
      if ({c_valid, c_bit, c_err, c_locked, c_errc, c_bitc} !==
          {1'b1, x_b, e_err, m_lock, m_errs[CW-1:0], m_bits[CW-1:0]}) begin
        failures++;
        $display("FAIL single_err bit%0d got e=%b l=%b ec=%0d bc=%0d exp e=%b l=%b ec=%0d bc=%0d",
                 i, c_err, c_locked, c_errc, c_bitc, e_err, m_lock, m_errs, m_bits);
      end
    end
    checks++;
    if (c_locked !== 1'b1) begin
      failures++;
      $display("FAIL flywheel_hold got locked=%b exp 1", c_locked);
    end
  endtask

  task automatic align_window();
    for (int i = 0; i < 40 && !(m_lock && m_win == 0); i++) tx_bit(1'b0);
  endtask

  task automatic test_loss_relock();
    align_window();
    for (int i = 0; i < 18; i++) begin
      tx_bit(i == 1 || i == 4 || i == 7);
      checks++;
      if ({c_valid, c_bit, c_err, c_locked, c_errc, c_bitc} !==
          {1'b1, x_b, e_err, m_lock, m_errs[CW-1:0], m_bits[CW-1:0]}) begin
        failures++;
        $display("FAIL loss_relock bit%0d got e=%b l=%b ec=%0d bc=%0d exp e=%b l=%b ec=%0d bc=%0d",
                 i, c_err, c_locked, c_errc, c_bitc, e_err, m_lock, m_errs, m_bits);
      end
      if (i == 7 || i == 16 || i == 17) begin
        checks++;
        if (c_locked !== (i == 17)) begin
          failures++;
          $display("FAIL loss_relock_edge bit%0d got locked=%b exp %b", i, c_locked, i == 17);
        end
      end
    end
  endtask

  task automatic test_window_errors();
    int p1, p2;
    align_window();
    for (int w = 0; w < 5; w++) begin
      p1 = $urandom_range(0, 7);
      p2 = $urandom_range(8, 15);
      for (int i = 0; i < WIN_LEN; i++) begin
        tx_bit(i == p1 || i == p2);
        checks++;
        if ({c_valid, c_bit, c_err, c_locked, c_errc, c_bitc} !==
            {1'b1, x_b, e_err, m_lock, m_errs[CW-1:0], m_bits[CW-1:0]}) begin
          failures++;
          $display("FAIL window_errs w%0d bit%0d got e=%b l=%b ec=%0d bc=%0d exp e=%b l=%b ec=%0d bc=%0d",
                   w, i, c_err, c_locked, c_errc, c_bitc, e_err, m_lock, m_errs, m_bits);
        end
      end
    end
    checks++;
    if (c_locked !== 1'b1) begin
      failures++;
      $display("FAIL window_errs_lock got locked=%b exp 1", c_locked);
    end
  endtask

  task automatic test_stuck();
    for (int i = 0; i < 80; i++) begin
      xfer_raw(i >= 50);
      checks++;
      if ({c_valid, c_bit, c_err, c_locked, c_errc, c_bitc} !==
          {1'b1, x_b, e_err, m_lock, m_errs[CW-1:0], m_bits[CW-1:0]}) begin
        failures++;
        $display("FAIL stuck bit%0d got b=%b e=%b l=%b ec=%0d bc=%0d exp b=%b e=%b l=%b ec=%0d bc=%0d",
                 i, c_bit, c_err, c_locked, c_errc, c_bitc, x_b, e_err, m_lock, m_errs, m_bits);
      end
      if (i == 49 || i == 79) begin
        checks++;
        if (c_locked !== 1'b0) begin
          failures++;
          $display("FAIL stuck_no_lock bit%0d got locked=%b exp 0", i, c_locked);
        end
      end
    end
  endtask

  task automatic test_random();
    tx_k = $urandom_range(0, 6);
    for (int i = 0; i < 80; i++) begin
      tx_bit(i >= 20 && $urandom_range(0, 7) == 0);
      checks++;
      if ({c_valid, c_bit, c_err, c_locked, c_errc, c_bitc} !==
          {1'b1, x_b, e_err, m_lock, m_errs[CW-1:0], m_bits[CW-1:0]}) begin
        failures++;
        $display("FAIL random bit%0d got b=%b e=%b l=%b ec=%0d bc=%0d exp b=%b e=%b l=%b ec=%0d bc=%0d",
                 i, c_bit, c_err, c_locked, c_errc, c_bitc, x_b, e_err, m_lock, m_errs, m_bits);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 30; i++) tx_bit(1'b0);
    @(negedge clk); #2; reset_n = 1'b0; #1;
    checks++;
    if ({rx_valid, rx_bit, bit_err, locked, err_cnt, bit_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_mid got v=%b b=%b e=%b l=%b ec=%0d bc=%0d exp all 0",
               rx_valid, rx_bit, bit_err, locked, err_cnt, bit_cnt);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #3; reset_n = 1'b1;
    tx_k = $urandom_range(0, 6);
    for (int i = 0; i < 12; i++) begin
      tx_bit(1'b0);
      checks++;
      if ({c_valid, c_bit, c_err, c_locked, c_errc, c_bitc} !==
          {1'b1, x_b, e_err, m_lock, m_errs[CW-1:0], m_bits[CW-1:0]}) begin
        failures++;
        $display("FAIL relock bit%0d got e=%b l=%b ec=%0d bc=%0d exp e=%b l=%b ec=%0d bc=%0d",
                 i, c_err, c_locked, c_errc, c_bitc, e_err, m_lock, m_errs, m_bits);
      end
      if (i == 9) begin
        checks++;
        if ({c_locked, c_errc} !== {1'b1, {CW{1'b0}}}) begin
          failures++;
          $display("FAIL relock_10th got locked=%b ec=%0d exp locked=1 ec=0", c_locked, c_errc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_single_error();
    test_loss_relock();
    test_window_errors();
    test_stuck();
    test_random();
    test_reset_mid();
    repeat (5) @(posedge clk);
    checks++;
    if (pulses !== sent || stray !== 0) begin
      failures++;
      $display("FAIL pulse_count got pulses=%0d stray_err=%0d exp pulses=%0d stray_err=0",
               pulses, stray, sent);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
